// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : traffic_sensor_conditioner
// Brief    : Conditions raw loop-detector and push-button inputs for the
//            traffic light controller: synchronizes, counts vehicles per
//            sampling window into density flags, debounces the ped button.
//            Optional macro PED_LATCH_EN latches the pedestrian request in an
//            IDLE/PENDING/SERVING FSM; without it ped_req is a 1-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WINDOW_CYCLES   = 16,
    parameter int HI_THRESH       = 5,
    parameter int LO_THRESH       = 2,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ns_veh_pulse,
    input  logic ew_veh_pulse,
    input  logic ped_button,
    input  logic ped_signal,
    output logic ns_density,
    output logic ew_density,
    output logic ped_req
);

    localparam int c_win_w = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int c_db_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_CYCLES - 1);
    localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max  = '1;
    localparam logic [CNT_W-1:0]   c_hi       = CNT_W'(HI_THRESH);
    localparam logic [CNT_W-1:0]   c_lo       = CNT_W'(LO_THRESH);

    logic [c_win_w-1:0] r_win;
    logic               w_win_last;
    logic [1:0]         w_veh_raw;
    logic [1:0]         w_density;

    assign w_win_last = (r_win == c_win_last);
    assign w_veh_raw  = {ew_veh_pulse, ns_veh_pulse};

    // Shared sampling window: counts 0..WINDOW_CYCLES-1 and wraps.
    always_ff @(posedge clk) begin
        if (reset)           r_win <= '0;
        else if (w_win_last) r_win <= '0;
        else                 r_win <= r_win + 1'b1;
    end

    // One identical vehicle channel per direction (0 = NS, 1 = EW).
    for (genvar d = 0; d < 2; d++) begin : g_dir
        logic [1:0]       r_sync;
        logic             r_prev;
        logic [CNT_W-1:0] r_cnt;
        logic             r_dens;
        logic             w_edge;
        logic [CNT_W-1:0] w_cnt_nxt;

        assign w_edge    = r_sync[1] & ~r_prev;
        // Saturating increment; also used as the count judged in the terminal
        // cycle so an edge landing there still counts toward this window.
        assign w_cnt_nxt = (w_edge && (r_cnt != c_cnt_max)) ? r_cnt + 1'b1 : r_cnt;

        // Two-flop synchronizer plus delayed copy for rising-edge detection.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync <= '0;
                r_prev <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_veh_raw[d]};
                r_prev <= r_sync[1];
            end
        end

        // Vehicle count per window with hysteretic density decision at the end.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt  <= '0;
                r_dens <= 1'b0;
            end else if (w_win_last) begin
                r_cnt <= '0;
                if (w_cnt_nxt >= c_hi)      r_dens <= 1'b1;
                else if (w_cnt_nxt <= c_lo) r_dens <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
            end
        end

        assign w_density[d] = r_dens;
    end

    assign ns_density = w_density[0];
    assign ew_density = w_density[1];

    logic [1:0]        r_btn_sync;
    logic [c_db_w-1:0] r_db_cnt;
    logic              r_db_level;
    logic              r_db_prev;
    logic              w_press;

    assign w_press = r_db_level & ~r_db_prev;

    // Button synchronizer and debouncer; any return to the current level
    // restarts the stability count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_sync <= '0;
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_btn_sync <= {r_btn_sync[0], ped_button};
            r_db_prev  <= r_db_level;
            if (r_btn_sync[1] == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_db_level <= r_btn_sync[1];
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    logic r_ped_req;

`ifdef PED_LATCH_EN
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_pending = 2'd1;
    localparam logic [1:0] c_st_serving = 2'd2;

    logic [1:0] r_ped_state;

    // Request latch: held until the controller shows walk, then wait for walk
    // to end before accepting another press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ped_state <= c_st_idle;
            r_ped_req   <= 1'b0;
        end else begin
            case (r_ped_state)
                c_st_idle: begin
                    if (w_press && !ped_signal) begin
                        r_ped_state <= c_st_pending;
                        r_ped_req   <= 1'b1;
                    end
                end
                c_st_pending: begin
                    if (ped_signal) begin
                        r_ped_state <= c_st_serving;
                        r_ped_req   <= 1'b0;
                    end
                end
                c_st_serving: begin
                    if (!ped_signal) r_ped_state <= c_st_idle;
                end
                default: begin
                    r_ped_state <= c_st_idle;
                    r_ped_req   <= 1'b0;
                end
            endcase
        end
    end
`else
    logic w_unused_ped_signal;
    assign w_unused_ped_signal = ped_signal;

    // Plain request: one registered pulse per debounced press.
    always_ff @(posedge clk) begin
        if (reset) r_ped_req <= 1'b0;
        else       r_ped_req <= w_press;
    end
`endif

    assign ped_req = r_ped_req;

endmodule
`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_sensor_conditioner
// Brief    : Directed self-checking bench for traffic_sensor_conditioner.
//            Expectations follow PED_LATCH_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_sensor_conditioner;

`ifdef PED_LATCH_EN
    localparam bit c_latch = 1'b1;
`else
    localparam bit c_latch = 1'b0;
`endif

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic ns_veh     = 1'b0;
    logic ew_veh     = 1'b0;
    logic ped_button = 1'b0;
    logic ped_signal = 1'b0;
    logic ns_density, ew_density, ped_req;

    logic sat_ns     = 1'b0;
    logic sat_zero   = 1'b0;
    logic sat_ns_density, sat_ew_density, sat_ped_req;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cnt = 0;
    int base;
    logic ped_req_q = 1'b0;

    traffic_sensor_conditioner u_dut (
        .clk          (clk),
        .reset        (reset),
        .ns_veh_pulse (ns_veh),
        .ew_veh_pulse (ew_veh),
        .ped_button   (ped_button),
        .ped_signal   (ped_signal),
        .ns_density   (ns_density),
        .ew_density   (ew_density),
        .ped_req      (ped_req)
    );

    // Long window and high threshold so a wrapped counter cannot reach it.
    traffic_sensor_conditioner #(
        .WINDOW_CYCLES (700),
        .HI_THRESH     (250)
    ) u_sat (
        .clk          (clk),
        .reset        (reset),
        .ns_veh_pulse (sat_ns),
        .ew_veh_pulse (sat_zero),
        .ped_button   (sat_zero),
        .ped_signal   (sat_zero),
        .ns_density   (sat_ns_density),
        .ew_density   (sat_ew_density),
        .ped_req      (sat_ped_req)
    );

    always #5 clk = ~clk;

    // Count rising edges of ped_req.
    always @(negedge clk) begin
        if (ped_req && !ped_req_q) rise_cnt++;
        ped_req_q <= ped_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Two reset edges; cyc 0 is the first cycle of a fresh window.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    // One vehicle = one cycle high, one cycle low.
    task automatic veh(input int nns, input int new_);
        int m;
        m = (nns > new_) ? nns : new_;
        for (int i = 0; i < m; i++) begin
            ns_veh = (i < nns);
            ew_veh = (i < new_);
            tick();
            ns_veh = 1'b0;
            ew_veh = 1'b0;
            tick();
        end
    endtask

    initial begin
        do_reset();
        chk("rst_ns", ns_density, 0);
        chk("rst_ew", ew_density, 0);
        chk("rst_ped", ped_req, 0);

        // Window 0: six NS vehicles -> set at cycle 16
        veh(6, 0);
        wait_to(15);
        chk("ns6_pre", ns_density, 0);
        tick();
        chk("ns6_set", ns_density, 1);
        chk("ew_idle", ew_density, 0);

        // Window 1: three vehicles -> hold
        veh(3, 0);
        wait_to(32);
        chk("ns3_hold", ns_density, 1);

        // Window 2: two vehicles -> clear at end only
        veh(2, 0);
        wait_to(40);
        chk("ns_mid_hold", ns_density, 1);
        wait_to(48);
        chk("ns2_clear", ns_density, 0);

        // Window 3: NS 4 (below HI), EW 5 (at HI)
        veh(4, 5);
        wait_to(64);
        chk("ns4_nohit", ns_density, 0);
        chk("ew5_set", ew_density, 1);

        // Window 4: fifth NS edge detected in the terminal cycle still counts
        wait_to(69);
        veh(5, 3);
        wait_to(80);
        chk("ns_term_edge", ns_density, 1);
        chk("ew3_hold", ew_density, 1);

        // Bouncy press: 1-0-1-0 then stable high from cycle 86
        wait_to(82);
        ped_button = 1'b1; tick();
        ped_button = 1'b0; tick();
        ped_button = 1'b1; tick();
        ped_button = 1'b0; tick();
        ped_button = 1'b1;
        base = rise_cnt;
        wait_to(92);
        chk("ped_early", ped_req, 0);
        tick();
        chk("ped_rise", ped_req, 1);
        wait_to(94);
        chk("ped_after", ped_req, c_latch ? 1 : 0);
        wait_to(96);
        ped_button = 1'b0;
        chk("ped_one_rise", rise_cnt - base, 1);

        // Walk served; a second press lands while SERVING
        wait_to(103);
        ped_button = 1'b1;
        wait_to(106);
        chk("ped_pending", ped_req, c_latch ? 1 : 0);
        ped_signal = 1'b1;
        base = rise_cnt;
        tick();
        chk("ped_fall", ped_req, 0);
        wait_to(110);
        chk("ped_press2", ped_req, c_latch ? 0 : 1);
        wait_to(111);
        ped_signal = 1'b0;
        wait_to(120);
        chk("ped_no_rearm", rise_cnt - base, c_latch ? 0 : 1);
        chk("ped_idle", ped_req, 0);
        ped_button = 1'b0;

        // Set up ped_req and ns_density, then reset at window cycle 10
        wait_to(128);
        ped_button = 1'b1;
        veh(6, 0);
        wait_to(143);
        veh(5, 0);
        wait_to(154);
        chk("pre_rst_ped", ped_req, c_latch ? 1 : 0);
        chk("pre_rst_ns", ns_density, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
        chk("mid_rst_ns", ns_density, 0);
        chk("mid_rst_ew", ew_density, 0);
        chk("mid_rst_ped", ped_req, 0);

        // Held button re-debounces into a new press
        wait_to(6);
        chk("rearm_early", ped_req, 0);
        tick();
        chk("rearm_press", ped_req, 1);
        wait_to(10);
        chk("rearm_hold", ped_req, c_latch ? 1 : 0);
        wait_to(16);
        chk("partial_discard", ns_density, 0);

        // Fresh window alignment after reset
        wait_to(17);
        veh(5, 0);
        wait_to(31);
        chk("fresh_pre", ns_density, 0);
        tick();
        chk("fresh_set", ns_density, 1);
        ped_button = 1'b0;

        // Saturation: 300 edges in one 700-cycle window
        do_reset();
        for (int i = 0; i < 300; i++) begin
            sat_ns = 1'b1;
            tick();
            sat_ns = 1'b0;
            tick();
        end
        wait_to(699);
        chk("sat_pre", sat_ns_density, 0);
        tick();
        chk("sat_set", sat_ns_density, 1);
        chk("sat_ew", sat_ew_density, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
